// File: rtl/fifo_rd_prefetch_if.sv
// fifo_rd_prefetch_if
//   Bundles the FIFO read-side handshake and the downstream valid/ready stream
//   for fifo_rd_prefetch.
//   Signals:
//     rd_empty  - FIFO empty flag (high: no pop allowed)
//     rd_data   - FIFO memory read data, valid one cycle after rd_inc
//     rd_inc    - pop request to the read-pointer/empty stage
//     out_valid - out_data holds a valid word
//     out_data  - head-of-stream word
//     out_ready - downstream accepts out_data this cycle
//     buf_cnt   - words held in the output buffer (0..2)
//   Modports: master = prefetch block, slave = FIFO read stage plus downstream.
interface fifo_rd_prefetch_if #(
    parameter int DSIZE = 8
);
    logic             rd_empty;
    logic [DSIZE-1:0] rd_data;
    logic             rd_inc;
    logic             out_valid;
    logic [DSIZE-1:0] out_data;
    logic             out_ready;
    logic [1:0]       buf_cnt;

    modport master (
        input  rd_empty, rd_data, out_ready,
        output rd_inc, out_valid, out_data, buf_cnt
    );

    modport slave (
        output rd_empty, rd_data, out_ready,
        input  rd_inc, out_valid, out_data, buf_cnt
    );
endinterface

// File: rtl/fifo_rd_prefetch.sv
// fifo_rd_prefetch
//   Turns a FIFO pop interface with a registered (1-cycle latency) read port
//   into a first-word-fall-through valid/ready stream using a 2-entry buffer
//   (slot0 = head, slot1 = next).
//   Ports:
//     rd_clk - read-domain clock, all state updates on its rising edge
//     rd_rst - synchronous active-high reset
//     bus    - fifo_rd_prefetch_if.master (rd_empty/rd_data/rd_inc,
//              out_valid/out_data/out_ready, buf_cnt)
//
//   state    | meaning
//   ---------+--------------------------------------------
//   ST_EMPTY | no word buffered, out_valid low
//   ST_ONE   | slot0 holds the head word
//   ST_TWO   | slot0 holds the head word, slot1 the next one
module fifo_rd_prefetch #(
    parameter int DSIZE = 8
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    fifo_rd_prefetch_if.master   bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state, state_next;
    logic             inflight;
    logic [DSIZE-1:0] slot0, slot1;
    logic [DSIZE-1:0] slot0_next, slot1_next;
    logic             pop;
    logic             arrive;
    logic [2:0]       occ;

    // Outputs come only from registered state, never from out_ready.
    assign bus.out_valid = (state != ST_EMPTY);
    assign bus.out_data  = slot0;
    assign bus.buf_cnt   = state;

    assign pop    = bus.out_valid && bus.out_ready;
    assign arrive = inflight;

    // Occupancy after this cycle counting the word already in flight; a
    // same-cycle pop frees its slot so streaming keeps one pop per cycle.
    assign occ        = {1'b0, state} + {2'b00, inflight} - {2'b00, pop};
    assign bus.rd_inc = !rd_rst && !bus.rd_empty && (occ < 3'd2);

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state    <= ST_EMPTY;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= bus.rd_inc;
        end
    end

    // Slot contents need no reset: out_valid masks them while empty.
    always_ff @(posedge rd_clk) begin
        slot0 <= slot0_next;
        slot1 <= slot1_next;
    end

    always_comb begin
        state_next = state;
        slot0_next = slot0;
        slot1_next = slot1;
        case (state)
            ST_EMPTY: begin
                if (arrive) begin
                    slot0_next = bus.rd_data;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (arrive && pop) begin
                    slot0_next = bus.rd_data;
                end else if (arrive) begin
                    slot1_next = bus.rd_data;
                    state_next = ST_TWO;
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Arrive without pop cannot happen here: rd_inc withholds
                // the pop request whenever the buffer would overflow.
                if (arrive && pop) begin
                    slot0_next = slot1;
                    slot1_next = bus.rd_data;
                end else if (pop) begin
                    slot0_next = slot1;
                    state_next = ST_ONE;
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_prefetch.sv
// tb_fifo_rd_prefetch
//   Directed bench for fifo_rd_prefetch. A behavioural FIFO (queue) answers
//   rd_inc with one-cycle read latency; a queue-based buffer model predicts
//   out_valid/buf_cnt/out_data/rd_inc every cycle, and directed steps check
//   latency, ordering, backpressure, random traffic and mid-stream reset.
module tb_fifo_rd_prefetch;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b1;

    fifo_rd_prefetch_if #(.DSIZE(8)) bus ();

    fifo_rd_prefetch #(.DSIZE(8)) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    always #5 rd_clk = ~rd_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int inc_count = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_buf[$];
    logic [7:0] acc[$];
    int         acc_cyc[$];
    logic [7:0] words[1000];

    logic       hold_empty = 1'b1;
    logic       model_ok   = 1'b0;
    logic       m_inf      = 1'b0;
    logic [7:0] m_word     = 8'h00;

    logic       snap_inc, snap_valid;
    logic [7:0] snap_data;
    logic [1:0] snap_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: settle inputs, sample and check outputs before the
    // edge, then advance the FIFO and buffer models after the edge.
    task automatic tick();
        int   nb;
        logic pop_s, exp_inc, rdy_s, rst_s;
        bus.rd_empty = hold_empty || (fifo_q.size() == 0);
        #3;
        snap_inc   = bus.rd_inc;
        snap_valid = bus.out_valid;
        snap_data  = bus.out_data;
        snap_cnt   = bus.buf_cnt;
        nb      = exp_buf.size();
        rdy_s   = bus.out_ready;
        rst_s   = rd_rst;
        pop_s   = (nb != 0) && rdy_s;
        exp_inc = !rst_s && !bus.rd_empty && ((nb + int'(m_inf) - int'(pop_s)) < 2);
        if (model_ok) begin
            chk("out_valid", {31'd0, snap_valid}, {31'd0, nb != 0});
            chk("buf_cnt", {30'd0, snap_cnt}, nb);
            chk("rd_inc", {31'd0, snap_inc}, {31'd0, exp_inc});
            if (nb != 0) chk("out_data", {24'd0, snap_data}, {24'd0, exp_buf[0]});
        end
        @(posedge rd_clk);
        cyc++;
        if (snap_valid === 1'b1 && rdy_s && !rst_s) begin
            acc.push_back(snap_data);
            acc_cyc.push_back(cyc);
        end
        if (snap_inc === 1'b1) inc_count++;
        if (rst_s) begin
            exp_buf.delete();
            m_inf    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (pop_s) void'(exp_buf.pop_front());
            if (m_inf) exp_buf.push_back(m_word);
            m_inf = exp_inc;
        end
        #1;
        if (snap_inc === 1'b1) begin
            if (fifo_q.size() > 0) bus.rd_data = fifo_q.pop_front();
            else bus.rd_data = 8'hxx;
        end
        m_word       = bus.rd_data;
        bus.rd_empty = hold_empty || (fifo_q.size() == 0);
    endtask

    initial begin
        bus.rd_empty  = 1'b1;
        bus.rd_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset, then idle with rd_empty high.
        tick();
        tick();
        rd_rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_rd_inc", {31'd0, snap_inc}, 0);
            chk("idle_valid", {31'd0, snap_valid}, 0);
            chk("idle_cnt", {30'd0, snap_cnt}, 0);
        end

        // Single word: rd_inc at N, out_valid at N+2, empty again at N+3.
        acc.delete();
        fifo_q.push_back(8'hA5);
        hold_empty    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("a5_inc_n", {31'd0, snap_inc}, 1);
        tick();
        chk("a5_inc_n1", {31'd0, snap_inc}, 0);
        chk("a5_valid_n1", {31'd0, snap_valid}, 0);
        tick();
        chk("a5_valid_n2", {31'd0, snap_valid}, 1);
        chk("a5_data_n2", {24'd0, snap_data}, 32'hA5);
        tick();
        chk("a5_cnt_n3", {30'd0, snap_cnt}, 0);
        chk("a5_accepted", acc.size(), 1);

        // Stream 0x01..0x10 with out_ready high: one word per cycle.
        acc.delete();
        acc_cyc.delete();
        for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 22; i++) tick();
        chk("s16_count", acc.size(), 16);
        for (int i = 0; i < acc.size() && i < 16; i++)
            chk("s16_order", {24'd0, acc[i]}, i + 1);
        if (acc.size() == 16) chk("s16_rate", acc_cyc[15] - acc_cyc[0], 15);

        // Backpressure: two pops fill the buffer, head stays put.
        bus.out_ready = 1'b0;
        inc_count = 0;
        acc.delete();
        acc_cyc.delete();
        for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i >= 3) begin
                chk("bp_hold_data", {24'd0, snap_data}, 1);
                chk("bp_hold_valid", {31'd0, snap_valid}, 1);
            end
        end
        chk("bp_pops", inc_count, 2);
        chk("bp_cnt", {30'd0, snap_cnt}, 2);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("bp_count", acc.size(), 8);
        for (int i = 0; i < acc.size() && i < 8; i++)
            chk("bp_order", {24'd0, acc[i]}, i + 1);
        if (acc.size() == 8) chk("bp_rate", acc_cyc[7] - acc_cyc[0], 7);

        // Random out_ready and rd_empty over 1000 words.
        acc.delete();
        acc_cyc.delete();
        for (int i = 0; i < 1000; i++) begin
            words[i] = 8'((i * 37 + 5) & 255);
            fifo_q.push_back(words[i]);
        end
        for (int n = 0; n < 20000 && acc.size() < 1000; n++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            hold_empty    = ($urandom_range(0, 9) < 3);
            tick();
        end
        hold_empty    = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("rand_count", acc.size(), 1000);
        for (int i = 0; i < acc.size() && i < 1000; i++)
            chk("rand_order", {24'd0, acc[i]}, {24'd0, words[i]});

        // Reset mid-stream with buffered and inflight words.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h11 + i));
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_cnt", {30'd0, snap_cnt}, 2);
        bus.out_ready = 1'b1;
        tick();
        chk("rst_pre_inc", {31'd0, snap_inc}, 1);
        rd_rst        = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        chk("rst_inc_low", {31'd0, snap_inc}, 0);
        rd_rst        = 1'b0;
        bus.out_ready = 1'b1;
        acc.delete();
        tick();
        chk("rst_post_valid", {31'd0, snap_valid}, 0);
        chk("rst_post_cnt", {30'd0, snap_cnt}, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("rst_fresh_count", acc.size(), 1);
        if (acc.size() > 0) chk("rst_fresh_word", {24'd0, acc[0]}, 32'h14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
